mc_control_fsm: RTL and testbench

- Main controller for the multicycle MIPS datapath.
- Takes op and funct fields from the instruction register and sequences fetch/decode/execute/memory/writeback.
- Drives all datapath enables and muxes, including IRWrite back into the instruction register.
- Moore FSM plus a combinational ALU-control decoder.

---
 rtl/mc_control_fsm.sv | 201 ++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mc_control_fsm
//   Main controller for the multicycle MIPS datapath. A Moore FSM sequences
//   fetch / decode / execute / memory / writeback from the IR op field, and a
//   combinational ALU-control decoder turns the internal ALUop plus the IR
//   funct field into the 3-bit ALU operation.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : synchronous, active-high; forces the state to FETCH
//   op, funct  : opcode / funct fields from the instruction register
//   IRWrite    : instruction register load enable
//   PCWrite    : unconditional PC write
//   Branch     : conditional PC write (ANDed with zero in the datapath)
//   MemWrite   : memory write strobe
//   IorD       : memory address select (0=PC, 1=ALUOut)
//   RegWrite   : register file write enable
//   RegDst     : destination register (0=rt, 1=rd)
//   MemtoReg   : writeback source (0=ALUOut, 1=MDR)
//   ALUSrcA    : ALU A input (0=PC, 1=reg A)
//   ALUSrcB    : ALU B input (00=B, 01=4, 10=SignImm, 11=SignImm<<2)
//   PCSrc      : next PC (00=ALUResult, 01=ALUOut, 10=jump target)
//   ALUControl : ALU operation code
//   state      : current state, for debug
// -----------------------------------------------------------------------------
module mc_control_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               Branch,
    output logic               MemWrite,
    output logic               IorD,
    output logic               RegWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSrc,
    output logic [2:0]         ALUControl,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = STATE_W'(0),
        S_DECODE   = STATE_W'(1),
        S_MEMADR   = STATE_W'(2),
        S_MEMREAD  = STATE_W'(3),
        S_MEMWB    = STATE_W'(4),
        S_MEMWRITE = STATE_W'(5),
        S_EXECUTE  = STATE_W'(6),
        S_ALUWB    = STATE_W'(7),
        S_BRANCH   = STATE_W'(8),
        S_ADDIEX   = STATE_W'(9),
        S_ADDIWB   = STATE_W'(10),
        S_JUMP     = STATE_W'(11)
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t r_state;

    // State register. Unused encodings fall into the default arm and
    // recover to FETCH on the next edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:   r_state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_RTYPE:     r_state <= S_EXECUTE;
                        OP_BEQ:       r_state <= S_BRANCH;
                        OP_ADDI:      r_state <= S_ADDIEX;
                        OP_J:         r_state <= S_JUMP;
                        default:      r_state <= S_FETCH;   // unknown op: NOP
                    endcase
                end
                S_MEMADR:  r_state <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD: r_state <= S_MEMWB;
                S_EXECUTE: r_state <= S_ALUWB;
                S_ADDIEX:  r_state <= S_ADDIWB;
                default:   r_state <= S_FETCH;
            endcase
        end
    end

    // Moore output decode from the current state.
    logic       w_irwrite, w_pcwrite, w_branch, w_memwrite, w_regwrite;
    logic       w_iord, w_regdst, w_memtoreg, w_alusrca, w_legal;
    logic [1:0] w_alusrcb, w_pcsrc, w_aluop;
    logic [2:0] w_aluctl;

    always_comb begin
        w_irwrite  = 1'b0;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        w_iord     = 1'b0;
        w_regdst   = 1'b0;
        w_memtoreg = 1'b0;
        w_alusrca  = 1'b0;
        w_alusrcb  = 2'b00;
        w_pcsrc    = 2'b00;
        w_aluop    = 2'b00;
        w_legal    = 1'b1;
        case (r_state)
            S_FETCH: begin
                w_irwrite = 1'b1;
                w_pcwrite = 1'b1;
                w_alusrcb = 2'b01;
            end
            S_DECODE:   w_alusrcb = 2'b11;
            S_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
            end
            S_MEMREAD:  w_iord = 1'b1;
            S_MEMWB: begin
                w_regwrite = 1'b1;
                w_memtoreg = 1'b1;
            end
            S_MEMWRITE: begin
                w_iord     = 1'b1;
                w_memwrite = 1'b1;
            end
            S_EXECUTE: begin
                w_alusrca = 1'b1;
                w_aluop   = 2'b10;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_regdst   = 1'b1;
            end
            S_BRANCH: begin
                w_alusrca = 1'b1;
                w_aluop   = 2'b01;
                w_pcsrc   = 2'b01;
                w_branch  = 1'b1;
            end
            S_ADDIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
            end
            S_ADDIWB:   w_regwrite = 1'b1;
            S_JUMP: begin
                w_pcwrite = 1'b1;
                w_pcsrc   = 2'b10;
            end
            default:    w_legal = 1'b0;   // illegal encoding: everything 0
        endcase
    end

    // ALU control decoder.
    always_comb begin
        w_aluctl = 3'b010;
        case (w_aluop)
            2'b01: w_aluctl = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100010: w_aluctl = 3'b110;
                    6'b100100: w_aluctl = 3'b000;
                    6'b100101: w_aluctl = 3'b001;
                    6'b101010: w_aluctl = 3'b111;
                    default:   w_aluctl = 3'b010;
                endcase
            end
            default: w_aluctl = 3'b010;
        endcase
        if (!w_legal) w_aluctl = 3'b000;
    end

    // Write strobes are masked while reset is high so an aborted instruction
    // cannot commit anything in the reset cycle itself.
    assign IRWrite    = w_irwrite  & ~reset;
    assign PCWrite    = w_pcwrite  & ~reset;
    assign Branch     = w_branch   & ~reset;
    assign MemWrite   = w_memwrite & ~reset;
    assign RegWrite   = w_regwrite & ~reset;
    assign IorD       = w_iord;
    assign RegDst     = w_regdst;
    assign MemtoReg   = w_memtoreg;
    assign ALUSrcA    = w_alusrca;
    assign ALUSrcB    = w_alusrcb;
    assign PCSrc      = w_pcsrc;
    assign ALUControl = w_aluctl;
    assign state      = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_control_fsm
//   Directed-vector bench. Each step drives reset/op/funct just after a rising
//   edge and pushes the hand-computed expected state and output vector into a
//   queue; a monitor on the falling edge pops and compares.
//   Output vector bit order:
//   {IRWrite,PCWrite,Branch,MemWrite, IorD,RegWrite,RegDst,MemtoReg,
//    ALUSrcA,ALUSrcB[1:0],PCSrc[1], PCSrc[0],ALUControl[2:0]}
// -----------------------------------------------------------------------------
module tb_mc_control_fsm;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       IRWrite, PCWrite, Branch, MemWrite, IorD, RegWrite;
    logic       RegDst, MemtoReg, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;

    mc_control_fsm #(.STATE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .Branch     (Branch),
        .MemWrite   (MemWrite),
        .IorD       (IorD),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .ALUControl (ALUControl),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] vec;
    } exp_t;

    // Hand-computed output vectors.
    localparam logic [15:0] V_FETCH   = 16'b1100_0000_0010_0010;
    localparam logic [15:0] V_FETCHRS = 16'b0000_0000_0010_0010; // FETCH, reset high
    localparam logic [15:0] V_DECODE  = 16'b0000_0000_0110_0010;
    localparam logic [15:0] V_MEMADR  = 16'b0000_0000_1100_0010;
    localparam logic [15:0] V_MEMREAD = 16'b0000_1000_0000_0010;
    localparam logic [15:0] V_MEMWB   = 16'b0000_0101_0000_0010;
    localparam logic [15:0] V_MEMWR   = 16'b0001_1000_0000_0010;
    localparam logic [15:0] V_EX_SLT  = 16'b0000_0000_1000_0111;
    localparam logic [15:0] V_EX_ADD  = 16'b0000_0000_1000_0010;
    localparam logic [15:0] V_EX_SUB  = 16'b0000_0000_1000_0110;
    localparam logic [15:0] V_EX_AND  = 16'b0000_0000_1000_0000;
    localparam logic [15:0] V_EX_OR   = 16'b0000_0000_1000_0001;
    localparam logic [15:0] V_ALUWB   = 16'b0000_0110_0000_0010;
    localparam logic [15:0] V_BRANCH  = 16'b0010_0000_1000_1110;
    localparam logic [15:0] V_ADDIEX  = 16'b0000_0000_1100_0010;
    localparam logic [15:0] V_ADDIWB  = 16'b0000_0100_0000_0010;
    localparam logic [15:0] V_JUMP    = 16'b0100_0000_0001_0010;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
    localparam logic [5:0] UNK = 6'b111111;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   done     = 1'b0;

    logic [15:0] w_act;
    assign w_act = {IRWrite, PCWrite, Branch, MemWrite, IorD, RegWrite, RegDst,
                    MemtoReg, ALUSrcA, ALUSrcB, PCSrc, ALUControl};

    // Monitor: compare whatever the DUT presents mid-cycle against the queue.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            if (state !== e.st || w_act !== e.vec) begin
                n_errors++;
                $display("FAIL step%0d: state=%0d vec=%b, required state=%0d vec=%b",
                         n_checks, state, w_act, e.st, e.vec);
            end
            // Structural invariants on every observed cycle.
            n_checks++;
            if ((PCWrite & Branch) | (MemWrite & RegWrite)) begin
                n_errors++;
                $display("FAIL excl%0d: PCW/Br=%b%b MW/RW=%b%b, required no pair both 1",
                         n_checks, PCWrite, Branch, MemWrite, RegWrite);
            end
        end
    end

    task automatic step(input logic rst, input logic [5:0] o, input logic [5:0] f,
                        input logic [3:0] st, input logic [15:0] v);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst;
        op    = o;
        funct = f;
        e.st  = st;
        e.vec = v;
        q.push_back(e);
    endtask

    initial begin
        reset = 1'b1;
        op    = 6'd0;
        funct = 6'd0;

        // Reset held two cycles, then first fetch.
        step(1, UNK, 0, 0, V_FETCHRS);
        step(1, UNK, 0, 0, V_FETCHRS);

        // lw: 0,1,2,3,4
        step(0, LW, 0, 0, V_FETCH);
        step(0, LW, 0, 1, V_DECODE);
        step(0, LW, 0, 2, V_MEMADR);
        step(0, LW, 0, 3, V_MEMREAD);
        step(0, LW, 0, 4, V_MEMWB);

        // sw: 0,1,2,5
        step(0, SW, 0, 0, V_FETCH);
        step(0, SW, 0, 1, V_DECODE);
        step(0, SW, 0, 2, V_MEMADR);
        step(0, SW, 0, 5, V_MEMWR);

        // R-type slt: 0,1,6,7
        step(0, RT, 6'b101010, 0, V_FETCH);
        step(0, RT, 6'b101010, 1, V_DECODE);
        step(0, RT, 6'b101010, 6, V_EX_SLT);
        step(0, RT, 6'b101010, 7, V_ALUWB);

        // Other R-type functs, observed in EXECUTE.
        step(0, RT, 6'b100000, 0, V_FETCH);
        step(0, RT, 6'b100000, 1, V_DECODE);
        step(0, RT, 6'b100010, 6, V_EX_SUB);  // funct read combinationally
        step(0, RT, 6'b100010, 7, V_ALUWB);
        step(0, RT, 6'b100100, 0, V_FETCH);
        step(0, RT, 6'b100100, 1, V_DECODE);
        step(0, RT, 6'b100100, 6, V_EX_AND);
        step(0, RT, 6'b100100, 7, V_ALUWB);
        step(0, RT, 6'b100101, 0, V_FETCH);
        step(0, RT, 6'b100101, 1, V_DECODE);
        step(0, RT, 6'b100101, 6, V_EX_OR);
        step(0, RT, 6'b100101, 7, V_ALUWB);
        step(0, RT, 6'b100000, 0, V_FETCH);
        step(0, RT, 6'b100000, 1, V_DECODE);
        step(0, RT, 6'b100000, 6, V_EX_ADD);
        step(0, RT, 6'b111000, 7, V_ALUWB);
        step(0, RT, 6'b111000, 0, V_FETCH);
        step(0, RT, 6'b111000, 1, V_DECODE);
        step(0, RT, 6'b111000, 6, V_EX_ADD);  // unknown funct -> add
        step(0, RT, 6'b111000, 7, V_ALUWB);

        // addi (IR 0x2129000A: op=001000, funct field=001010): 0,1,9,10
        step(0, ADDI, 6'b001010, 0, V_FETCH);
        step(0, ADDI, 6'b001010, 1, V_DECODE);
        step(0, ADDI, 6'b001010, 9, V_ADDIEX);
        step(0, ADDI, 6'b001010, 10, V_ADDIWB);

        // beq: 0,1,8 ; j: 0,1,11
        step(0, BEQ, 0, 0, V_FETCH);
        step(0, BEQ, 0, 1, V_DECODE);
        step(0, BEQ, 0, 8, V_BRANCH);
        step(0, JMP, 0, 0, V_FETCH);
        step(0, JMP, 0, 1, V_DECODE);
        step(0, JMP, 0, 11, V_JUMP);

        // Unknown op: 0,1,0
        step(0, UNK, 0, 0, V_FETCH);
        step(0, UNK, 0, 1, V_DECODE);
        step(0, UNK, 0, 0, V_FETCH);
        step(0, UNK, 0, 1, V_DECODE);

        // Back to FETCH, then lw aborted by reset while in MEMREAD.
        step(0, LW, 0, 0, V_FETCH);
        step(0, LW, 0, 1, V_DECODE);
        step(0, LW, 0, 2, V_MEMADR);
        step(1, LW, 0, 3, V_MEMREAD);         // reset high in state 3
        step(0, LW, 0, 0, V_FETCH);           // aborted: FETCH, not MEMWB
        step(0, LW, 0, 1, V_DECODE);

        @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL timeout: bench did not complete, required completion");
            $fatal(1, "timeout");
        end
    end

endmodule
